// File: rtl/csa_pkg.sv
// csa_pipe shared definitions: default geometry and the
// stage-1 per-block record carried between the two stages.
package csa_pkg;

    localparam int CSA_WIDTH = 16;
    localparam int CSA_BLOCK = 4;

    typedef struct packed {
        logic [CSA_BLOCK-1:0] sum0;
        logic [CSA_BLOCK-1:0] sum1;
        logic                 c0;
        logic                 c1;
    } csa_blk_t;

endpackage

// File: rtl/csa_pipe_if.sv
// csa_pipe operand/result bundle with valid/ready on both sides.
// master = producer+consumer, slave = the adder pipeline.
interface csa_pipe_if
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, carry, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, carry, ovf
    );

endinterface

// File: rtl/csa_pipe_adder_n.sv
// adder_n: N-bit ripple-carry adder used for each carry-select
// block, evaluated once per assumed carry-in.
module adder_n
    import csa_pkg::*;
#(
    parameter int N = CSA_BLOCK
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         carry_in,
    output logic [N-1:0] s,
    output logic         carry_out
);

    logic c;

    // ripple the carry bit by bit through the block
    always_comb begin
        c = carry_in;
        s = '0;
        for (int k = 0; k < N; k++) begin
            s[k] = x[k] ^ y[k] ^ c;
            c    = (x[k] & y[k]) | (c & (x[k] ^ y[k]));
        end
        carry_out = c;
    end

endmodule

// File: rtl/csa_pipe.sv
// csa_pipe: two-stage carry-select adder/subtractor.
// Stage 1 forms both block results, stage 2 resolves the select chain.
module csa_pipe
    import csa_pkg::*;
#(
    parameter int  WIDTH = CSA_WIDTH,
    parameter int  BLOCK = CSA_BLOCK,
    parameter type blk_t = csa_blk_t
) (
    input logic       clk,
    input logic       rst,
    csa_pipe_if.slave bus
);

    localparam int NB = WIDTH / BLOCK;

    if ((BLOCK < 1) || (WIDTH % BLOCK != 0) ||
        (WIDTH < 2 * BLOCK) ||
        ($bits(blk_t) != 2 * BLOCK + 2)) begin : g_bad_geom
        $error("csa_pipe: illegal WIDTH/BLOCK combination");
    end

    logic [WIDTH-1:0] bx;
    logic             c_eff;

    // subtraction is A + ~B + 1, so cin is forced high
    assign bx    = bus.sub ? ~bus.b : bus.b;
    assign c_eff = bus.sub | bus.cin;

    blk_t n1_blk [NB];
    blk_t s1_blk [NB];
    logic v1;
    logic am1;
    logic bm1;

    for (genvar gi = 0; gi < NB; gi++) begin : g_blk
        if (gi == 0) begin : g_lo
            logic [BLOCK-1:0] s;
            logic             co;

            adder_n #(.N(BLOCK)) u_add (
                .x        (bus.a[BLOCK-1:0]),
                .y        (bx[BLOCK-1:0]),
                .carry_in (c_eff),
                .s        (s),
                .carry_out(co)
            );

            // block 0 knows its real carry-in; both slots agree
            assign n1_blk[gi] = '{sum0: s, sum1: s, c0: co, c1: co};
        end else begin : g_hi
            logic [BLOCK-1:0] s0;
            logic [BLOCK-1:0] s1;
            logic             co0;
            logic             co1;

            adder_n #(.N(BLOCK)) u_add0 (
                .x        (bus.a[gi*BLOCK +: BLOCK]),
                .y        (bx[gi*BLOCK +: BLOCK]),
                .carry_in (1'b0),
                .s        (s0),
                .carry_out(co0)
            );

            adder_n #(.N(BLOCK)) u_add1 (
                .x        (bus.a[gi*BLOCK +: BLOCK]),
                .y        (bx[gi*BLOCK +: BLOCK]),
                .carry_in (1'b1),
                .s        (s1),
                .carry_out(co1)
            );

            assign n1_blk[gi] = '{sum0: s0, sum1: s1, c0: co0, c1: co1};
        end
    end

    logic             ld1;
    logic             ld2;
    logic             v2;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             ovf_q;

    assign ld2 = !v2 || bus.out_ready;
    assign ld1 = !v1 || ld2;

    assign bus.in_ready  = ld1;
    assign bus.out_valid = v2;
    assign bus.sum       = sum_q;
    assign bus.carry     = carry_q;
    assign bus.ovf       = ovf_q;

    // stage-1 valid: follows in_valid whenever the stage advances
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
        end else if (ld1) begin
            v1 <= bus.in_valid;
        end
    end

    // stage-1 payload: both candidate block results plus operand MSBs
    always_ff @(posedge clk) begin
        if (ld1 && bus.in_valid) begin
            s1_blk <= n1_blk;
            am1    <= bus.a[WIDTH-1];
            bm1    <= bx[WIDTH-1];
        end
    end

    logic [WIDTH-1:0] n2_sum;
    logic             n2_carry;
    logic             n2_ovf;
    logic             c;

    // walk the select chain: each block picks by the previous carry
    always_comb begin
        c      = 1'b0;
        n2_sum = '0;
        for (int k = 0; k < NB; k++) begin
            n2_sum[k*BLOCK +: BLOCK] = c ? s1_blk[k].sum1 : s1_blk[k].sum0;
            c = c ? s1_blk[k].c1 : s1_blk[k].c0;
        end
        n2_carry = c;
        n2_ovf   = (am1 == bm1) && (n2_sum[WIDTH-1] != am1);
    end

    // stage-2 result register, frozen while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            v2      <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (ld2) begin
            v2 <= v1;
            if (v1) begin
                sum_q   <= n2_sum;
                carry_q <= n2_carry;
                ovf_q   <= n2_ovf;
            end
        end
    end

endmodule

// File: tb/tb_csa_pipe.sv
// Directed and random checks for csa_pipe at WIDTH=16, BLOCK=4.
module tb_csa_pipe;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    csa_pipe_if #(.WIDTH(16)) bus ();

    csa_pipe #(.WIDTH(16), .BLOCK(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        c;
        logic        o;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] model(
        input logic [15:0] a, input logic [15:0] b,
        input logic cin, input logic sub);
        logic [15:0] bx;
        logic [16:0] r;
        logic        o;
        bx = sub ? ~b : b;
        r  = {1'b0, a} + {1'b0, bx} + {16'd0, (sub | cin)};
        o  = (a[15] == bx[15]) && (r[15] != a[15]);
        return {r[16], o, r[15:0]};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a         = 16'h0001;
        bus.b         = 16'h0001;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) step();
        n_total++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL rst_ov: got %b want 0", bus.out_valid);
        else n_pass++;
        n_total++;
        if (bus.sum !== 16'h0000)
            $display("FAIL rst_sum: got %h want 0000", bus.sum);
        else n_pass++;
        n_total++;
        if (bus.carry !== 1'b0)
            $display("FAIL rst_carry: got %b want 0", bus.carry);
        else n_pass++;
        n_total++;
        if (bus.ovf !== 1'b0)
            $display("FAIL rst_ovf: got %b want 0", bus.ovf);
        else n_pass++;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        n_total++;
        if (bus.in_ready !== 1'b1)
            $display("FAIL rst_rdy: got %b want 1", bus.in_ready);
        else n_pass++;
        step();
        step();
        n_total++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL rst_stale: got %b want 0", bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_ops();
        vec_t v [9];
        v[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        v[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        v[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        v[3] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        v[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        v[5] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        v[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        v[7] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        v[8] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.a        = v[i].a;
            bus.b        = v[i].b;
            bus.cin      = v[i].cin;
            bus.sub      = v[i].sub;
            bus.in_valid = 1'b1;
            #1;
            n_total++;
            if (bus.in_ready !== 1'b1)
                $display("FAIL op%0d_rdy: got %b want 1", i, bus.in_ready);
            else n_pass++;
            step();
            bus.in_valid = 1'b0;
            n_total++;
            if (bus.out_valid !== 1'b0)
                $display("FAIL op%0d_early: got %b want 0", i, bus.out_valid);
            else n_pass++;
            step();
            n_total++;
            if (bus.out_valid !== 1'b1)
                $display("FAIL op%0d_ov: got %b want 1", i, bus.out_valid);
            else n_pass++;
            n_total++;
            if (bus.sum !== v[i].s)
                $display("FAIL op%0d_sum: got %h want %h", i, bus.sum, v[i].s);
            else n_pass++;
            n_total++;
            if (bus.carry !== v[i].c)
                $display("FAIL op%0d_carry: got %b want %b", i, bus.carry, v[i].c);
            else n_pass++;
            n_total++;
            if (bus.ovf !== v[i].o)
                $display("FAIL op%0d_ovf: got %b want %b", i, bus.ovf, v[i].o);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] got [3];
        int          n_got;
        logic        xin;
        bus.out_ready = 1'b0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            bus.a        = 16'(i);
            bus.b        = 16'(i);
            bus.in_valid = 1'b1;
            #1;
            n_total++;
            if (bus.in_ready !== 1'b1)
                $display("FAIL b2b_rdy%0d: got %b want 1", i, bus.in_ready);
            else n_pass++;
            step();
        end
        bus.a = 16'd3;
        bus.b = 16'd3;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) step();
            n_total++;
            if (bus.in_ready !== 1'b0)
                $display("FAIL b2b_full%0d: got %b want 0", i, bus.in_ready);
            else n_pass++;
            n_total++;
            if (bus.out_valid !== 1'b1 || bus.sum !== 16'd2)
                $display("FAIL b2b_hold%0d: got %b/%h want 1/0002",
                         i, bus.out_valid, bus.sum);
            else n_pass++;
        end
        bus.out_ready = 1'b1;
        #1;
        n_got = 0;
        for (int cyc = 0; cyc < 10 && n_got < 3; cyc++) begin
            if (bus.out_valid && bus.out_ready) begin
                got[n_got] = bus.sum;
                n_got++;
            end
            xin = bus.in_valid && bus.in_ready;
            step();
            if (xin) bus.in_valid = 1'b0;
            #1;
        end
        n_total++;
        if (n_got !== 3)
            $display("FAIL b2b_count: got %0d want 3", n_got);
        else n_pass++;
        for (int i = 0; i < n_got; i++) begin
            n_total++;
            if (got[i] !== 16'(2 * (i + 1)))
                $display("FAIL b2b_res%0d: got %h want %h", i, got[i], 16'(2 * (i + 1)));
            else n_pass++;
        end
        n_total++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL b2b_drain: got %b want 0", bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic stale;
        bus.out_ready = 1'b0;
        bus.sub       = 1'b0;
        bus.cin       = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a = 16'd5;
        bus.b = 16'd5;
        step();
        bus.a = 16'd6;
        bus.b = 16'd6;
        step();
        bus.in_valid = 1'b0;
        n_total++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
            $display("FAIL mid_full: got %b/%b want 1/0", bus.out_valid, bus.in_ready);
        else n_pass++;
        rst = 1'b1;
        step();
        n_total++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL mid_ov: got %b want 0", bus.out_valid);
        else n_pass++;
        n_total++;
        if (bus.sum !== 16'h0000)
            $display("FAIL mid_sum: got %h want 0000", bus.sum);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if (bus.in_ready !== 1'b1)
            $display("FAIL mid_rdy: got %b want 1", bus.in_ready);
        else n_pass++;
        bus.out_ready = 1'b1;
        stale = 1'b0;
        repeat (4) begin
            step();
            if (bus.out_valid) stale = 1'b1;
        end
        n_total++;
        if (stale !== 1'b0)
            $display("FAIL mid_stale: got %b want 0", stale);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [17:0] q [$];
        logic [17:0] e;
        logic [17:0] o;
        logic [15:0] edge_v [4];
        logic        xin;
        edge_v[0] = 16'h0000;
        edge_v[1] = 16'hFFFF;
        edge_v[2] = 16'h7FFF;
        edge_v[3] = 16'h8000;
        bus.in_valid = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (!bus.in_valid && $urandom_range(0, 9) < 7) begin
                bus.a = ($urandom_range(0, 3) == 0) ?
                        edge_v[$urandom_range(0, 3)] : 16'($urandom);
                bus.b = ($urandom_range(0, 3) == 0) ?
                        edge_v[$urandom_range(0, 3)] : 16'($urandom);
                bus.cin      = 1'($urandom);
                bus.sub      = 1'($urandom);
                bus.in_valid = 1'b1;
            end
            bus.out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                o = {bus.carry, bus.ovf, bus.sum};
                n_total++;
                if (q.size() == 0) begin
                    $display("FAIL rnd_extra: got %h want none", o);
                end else begin
                    e = q.pop_front();
                    if (o !== e)
                        $display("FAIL rnd_res: got %h want %h", o, e);
                    else n_pass++;
                end
            end
            xin = bus.in_valid && bus.in_ready;
            if (xin) q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
            step();
            if (xin) bus.in_valid = 1'b0;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            #1;
            if (bus.out_valid) begin
                o = {bus.carry, bus.ovf, bus.sum};
                n_total++;
                if (q.size() == 0) begin
                    $display("FAIL rnd_extra: got %h want none", o);
                end else begin
                    e = q.pop_front();
                    if (o !== e)
                        $display("FAIL rnd_res: got %h want %h", o, e);
                    else n_pass++;
                end
            end
            step();
        end
        n_total++;
        if (q.size() != 0)
            $display("FAIL rnd_drain: got %0d left want 0", q.size());
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_ops();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
